// File: rtl/elevator_scheduler.sv
// SCAN request scheduler and motion sequencer for a 3-floor car.
// Latency: a call latched at edge N starts motion or opens the door at edge N+1; one floor takes TRAVEL_CYCLES.
// Backpressure: none; calls are level inputs that latch into pending until their floor is served.
module elevator_scheduler #(
   parameter logic [1:0]  LABEL_F1      = 2'b00,
   parameter logic [1:0]  LABEL_F2      = 2'b01,
   parameter logic [1:0]  LABEL_F3      = 2'b10,
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic [1:0] floor,
   output logic [1:0] goal_floor,
   output logic       dir_up,
   output logic       moving,
   output logic       door
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
   localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] pos_q, pos_d;
   logic [2:0] pending_q, pending_d;
   logic       dir_up_q, dir_up_d;
   logic       moving_q, moving_d;
   logic       door_q, door_d;
   logic [7:0] timer_q, timer_d;

   logic [2:0] buttons;
   logic [2:0] here_mask;
   logic [2:0] below_mask;
   logic [2:0] up_pend;
   logic [2:0] dn_pend;
   logic [1:0] up_idx;
   logic [1:0] dn_idx;
   logic [1:0] goal_idx;
   logic [1:0] next_pos;
   logic [2:0] next_mask;
   logic       at_end;

   // Position is kept as a 0..2 index internally; labels are applied only at the outputs.
   function automatic logic [1:0] to_label(input logic [1:0] idx);
      case (idx)
         2'd0:    to_label = LABEL_F1;
         2'd1:    to_label = LABEL_F2;
         default: to_label = LABEL_F3;
      endcase
   endfunction

   assign buttons = {button3, button2, button1};

   always_comb begin
      here_mask  = 3'b001 << pos_q;
      below_mask = here_mask - 3'd1;
      up_pend    = pending_q & ~(here_mask | below_mask);
      dn_pend    = pending_q & below_mask;
      // Nearest above is the lowest set bit above; nearest below is the highest set bit below.
      up_idx     = up_pend[1] ? 2'd1 : 2'd2;
      dn_idx     = dn_pend[1] ? 2'd1 : 2'd0;
      goal_idx   = pos_q;
      if (dir_up_q) begin
         if (|up_pend) begin
            goal_idx = up_idx;
         end else if (|dn_pend) begin
            goal_idx = dn_idx;
         end
      end else begin
         if (|dn_pend) begin
            goal_idx = dn_idx;
         end else if (|up_pend) begin
            goal_idx = up_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      dir_up_d  = dir_up_q;
      timer_d   = timer_q;
      pending_d = pending_q | buttons;
      at_end    = dir_up_q ? (pos_q == 2'd2) : (pos_q == 2'd0);
      next_pos  = dir_up_q ? (pos_q + 2'd1) : (pos_q - 2'd1);
      next_mask = 3'b001 << next_pos;

      case (state_q)
         IDLE: begin
            if (|(pending_q & here_mask)) begin
               state_d   = DOOR;
               pending_d = pending_d & ~here_mask;
               timer_d   = DOOR_LOAD;
            end else if (|pending_q) begin
               // goal already prefers the current direction, so this only flips when nothing is ahead
               state_d  = MOVE;
               dir_up_d = (goal_idx > pos_q);
               timer_d  = TRAVEL_LOAD;
            end
         end
         MOVE: begin
            if (timer_q != 8'd0) begin
               timer_d = timer_q - 8'd1;
            end else if (at_end) begin
               dir_up_d = ~dir_up_q;
               timer_d  = TRAVEL_LOAD;
            end else begin
               pos_d   = next_pos;
               timer_d = TRAVEL_LOAD;
               if (|(pending_d & next_mask)) begin
                  state_d   = DOOR;
                  pending_d = pending_d & ~next_mask;
                  timer_d   = DOOR_LOAD;
               end
            end
         end
         DOOR: begin
            // A call for the open floor extends the dwell instead of queuing a revisit.
            pending_d = pending_d & ~here_mask;
            if (|(buttons & here_mask)) begin
               timer_d = DOOR_LOAD;
            end else if (timer_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      moving_d = (state_d == MOVE);
      door_d   = (state_d == DOOR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pos_q     <= 2'd0;
         pending_q <= 3'b000;
         dir_up_q  <= 1'b1;
         moving_q  <= 1'b0;
         door_q    <= 1'b0;
         timer_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         pending_q <= pending_d;
         dir_up_q  <= dir_up_d;
         moving_q  <= moving_d;
         door_q    <= door_d;
         timer_q   <= timer_d;
      end
   end

   assign led1       = pending_q[0];
   assign led2       = pending_q[1];
   assign led3       = pending_q[2];
   assign floor      = to_label(pos_q);
   assign goal_floor = to_label(goal_idx);
   assign dir_up     = dir_up_q;
   assign moving     = moving_q;
   assign door       = door_q;

endmodule
